// File: rtl/mealy_seq_detector.sv
// Serial Mealy detector for a LEN-bit PATTERN (MSB received first); outp flags the final bit in the same cycle.
// Latency: zero cycles, outp is combinational from state and inp. No backpressure: one bit consumed every edge.
// Optional MEALY_DET_COUNT_EN adds det_cnt, an 8-bit saturating detection counter.
module mealy_seq_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inp,
  output logic       outp
`ifdef MEALY_DET_COUNT_EN
  ,
  output logic [7:0] det_cnt
`endif
);

  localparam int SW = $clog2(LEN);
  typedef logic [SW-1:0] state_t;

  localparam state_t S0    = '0;
  localparam state_t SLAST = state_t'(LEN - 1);

  // Next state from Sk on bit b: the longest pattern prefix that is a suffix
  // of (first k pattern bits, then b). It is capped at LEN-1 so a full match
  // falls back to the longest proper border; without overlap a full match restarts at S0.
  function automatic int fallback(input int k, input logic b);
    logic [LEN-1:0] s;
    int             best;
    logic           ok;
    s = '0;
    for (int i = 0; i < k; i++) s[i] = PATTERN[LEN-1-i];
    s[k] = b;
    best = 0;
    for (int l = 1; l <= LEN - 1; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < l; m++) begin
          if (s[k+1-l+m] != PATTERN[LEN-1-m]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    if (!OVERLAP && (k == LEN - 1) && (b == PATTERN[0])) best = 0;
    return best;
  endfunction

  state_t state_q, state_d;
  state_t nxt_on0 [LEN];
  state_t nxt_on1 [LEN];

  // Transition table, fixed at elaboration: one entry per state and input bit.
  for (genvar k = 0; k < LEN; k++) begin : g_tbl
    localparam state_t N0 = state_t'(fallback(k, 1'b0));
    localparam state_t N1 = state_t'(fallback(k, 1'b1));
    assign nxt_on0[k] = N0;
    assign nxt_on1[k] = N1;
  end

  // Next state and Mealy output; reset forces S0 and suppresses outp.
  always_comb begin
    state_d = state_q;
    outp    = 1'b0;
    if (!rst) begin
      state_d = S0;
    end else if (state_q > SLAST) begin
      // Unused codes when LEN is not a power of two: recover to empty match.
      state_d = S0;
    end else begin
      state_d = inp ? nxt_on1[state_q] : nxt_on0[state_q];
      outp    = (state_q == SLAST) && (inp == PATTERN[0]);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

`ifdef MEALY_DET_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating detection count, cleared by reset.
  always_comb begin
    cnt_d = cnt_q;
    if (!rst)                         cnt_d = 8'd0;
    else if (outp && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign det_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: overlapping and non-overlapping instances share one stimulus stream.
// Expected outp values come from a shift-history model and are queued at drive time, popped at check.
// Counter checks are compiled in when MEALY_DET_COUNT_EN is defined.
module tb_mealy_seq_detector;

  localparam int             LEN = 4;
  localparam logic [LEN-1:0] PAT = 4'b1011;

  logic clk;
  logic rst;
  logic inp;
  logic outp1;
  logic outp0;
`ifdef MEALY_DET_COUNT_EN
  logic [7:0] det_cnt1;
  logic [7:0] det_cnt0;
`endif

  mealy_seq_detector #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b1)) u_ovl (
    .clk (clk),
    .rst (rst),
    .inp (inp),
    .outp(outp1)
`ifdef MEALY_DET_COUNT_EN
    ,
    .det_cnt(det_cnt1)
`endif
  );

  mealy_seq_detector #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b0)) u_novl (
    .clk (clk),
    .rst (rst),
    .inp (inp),
    .outp(outp0)
`ifdef MEALY_DET_COUNT_EN
    ,
    .det_cnt(det_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard queues and reference model state.
  logic           q1 [$];
  logic           q0 [$];
  logic [LEN-1:0] hist = '0;
  int             cnt1 = 0;
  int             cnt0 = 0;
  int             ecnt1 = 0;
  int             ecnt0 = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one bit (called at negedge), check outputs mid-cycle, advance one edge.
  task automatic step(input string tag, input logic b, input logic r);
    logic [LEN-1:0] nh;
    logic           e1, e0, o1, o0;
    nh = {hist[LEN-2:0], b};
    e1 = r && (cnt1 + 1 >= LEN) && (nh == PAT);
    e0 = r && (cnt0 + 1 >= LEN) && (nh == PAT);
    q1.push_back(e1);
    q0.push_back(e0);
    inp = b;
    rst = r;
    #2;
    o1 = q1.pop_front();
    o0 = q0.pop_front();
    check_bit({tag, "_ovl"}, outp1, o1);
    check_bit({tag, "_novl"}, outp0, o0);
    @(posedge clk);
    if (!r) begin
      hist  = '0;
      cnt1  = 0;
      cnt0  = 0;
      ecnt1 = 0;
      ecnt0 = 0;
    end else begin
      hist = nh;
      if (cnt1 < 1000) cnt1++;
      if (e0) cnt0 = 0;
      else if (cnt0 < 1000) cnt0++;
      if (e1 && ecnt1 < 255) ecnt1++;
      if (e0 && ecnt0 < 255) ecnt0++;
    end
    @(negedge clk);
  endtask

  task automatic stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b1);
  endtask

  task automatic check_counts(input string tag);
`ifdef MEALY_DET_COUNT_EN
    check_cnt({tag, "_cnt_ovl"}, int'(det_cnt1), ecnt1);
    check_cnt({tag, "_cnt_novl"}, int'(det_cnt0), ecnt0);
`else
    check_cnt({tag, "_queue_empty"}, q1.size() + q0.size(), 0);
`endif
  endtask

  initial begin
    inp = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Reset held three edges with inp=1: outp must stay low.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0);
    check_counts("after_reset");

    // 1011011: overlap detects at bits 3 and 6, non-overlap at bit 3 only.
    stream("overlap_stream", 32'b1011011, 7);
    check_counts("overlap_stream");
    step("reset_a", 1'b1, 1'b0);

    // 101011: the 1010 fallback lands in S2, detect on bit 5.
    stream("fallback_1010", 32'b101011, 6);
    step("reset_b", 1'b0, 1'b0);

    // 11011: S1 stays on 1, detect on bit 4.
    stream("fallback_11", 32'b11011, 5);
    step("reset_c", 1'b1, 1'b0);

    // Partial 101 then reset in place of the final 1, then a fresh 1011.
    stream("partial", 32'b101, 3);
    step("mid_reset", 1'b1, 1'b0);
    step("post_reset", 1'b1, 1'b1);
    stream("redetect", 32'b1011, 4);
    check_counts("redetect");

    // Random stream against the history model.
    for (int i = 0; i < 200; i++) step("random", 1'($urandom_range(0, 1)), 1'b1);
    check_counts("random");

`ifdef MEALY_DET_COUNT_EN
    // Saturation: 1 then 011 repeated 300 times, then one reset edge.
    step("sat_reset", 1'b0, 1'b0);
    step("sat_lead", 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      stream("sat_run", 32'b011, 3);
      if (i == 9) check_cnt("cnt_ten", int'(det_cnt1), 10);
    end
    check_cnt("cnt_saturated", int'(det_cnt1), 255);
    check_counts("saturation");
    step("sat_clear", 1'b1, 1'b0);
    check_cnt("cnt_cleared_ovl", int'(det_cnt1), 0);
    check_cnt("cnt_cleared_novl", int'(det_cnt0), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
- Serial Mealy-type sequence detector. Samples a 1-bit input stream once per clock and flags, combinationally and in the same cycle, when the last bit of a programmable pattern arrives.
- Sits between a serial bit source and any logic that must react to a framing or sync pattern with zero added latency.
- Pattern length, pattern value and overlap policy are set by elaboration-time parameters.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern to detect, LEN bits wide. The MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detections allowed; 0 = matching restarts from empty after each detection.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- inp  input  1  serial data bit, sampled on each rising edge.
- outp  output  1  Mealy detect flag; combinational from current state and inp.

Behaviour:
- State encoding: states S0..S(LEN-1), where Sk means the last k received bits equal the first k bits of PATTERN. State register width is clog2(LEN).
- Reset: when rst==0 at a rising edge, next state is S0.
- outp is forced to 0 whenever rst==0, independent of state and inp.
- Match step: in Sk, if inp equals PATTERN bit (LEN-1-k), the bit matches.
  - For k<LEN-1: next state is S(k+1), outp=0.
- Detection: in S(LEN-1) with a matching inp, outp=1 during that cycle, while inp is stable before the edge. Zero cycles of latency.
  - Next state with OVERLAP=1: S(f), where f is the length of the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - Next state with OVERLAP=0: S0.
- Mismatch: next state is S(j), where j is the length of the longest prefix of PATTERN that is a suffix of (matched k bits followed by inp). outp=0.
- The fallback table is computed at elaboration (constant function or generate). No runtime table.
- For the default 1011 pattern:
  - S0 with 0 stays in S0.
  - S1 with 1 stays in S1.
  - S2 with 0 goes to S0.
  - S3 with 0 goes to S2.
  - Detection goes to S1 (overlap) or S0 (no overlap).
- outp is never asserted more than once per clock and never for a partial match.
- Reset mid-sequence: any partial match is discarded. The first bit sampled after rst returns high starts matching from S0.
- X/Z on inp is not handled. Sources drive 0/1 only.
- No other outputs. No enable: every rising edge with rst high consumes one bit.

Optional Feature:
- Macro: MEALY_DET_COUNT_EN.
- When defined:
  - Adds output det_cnt (8 bits): a saturating count of detections.
  - Increments on each rising edge where outp==1, and holds at 255.
  - Cleared to 0 by synchronous reset.
- When undefined: det_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Hold rst=0 for 3 edges with inp=1, then release -> outp=0 throughout reset. Detection begins from S0 on the first sampled bit after release.
- Default params, OVERLAP=1, stream 1,0,1,1,0,1,1 -> outp=1 exactly on bits 3 and 6 (0-based), 0 elsewhere.
- OVERLAP=0, same stream 1,0,1,1,0,1,1 -> outp=1 only on bit 3.
- Fallback check, stream 1,0,1,0,1,1 -> the 1010 fallback goes to S2, and outp=1 on bit 5 only. Stream 1,1,0,1,1 -> outp=1 on bit 4 only.
- Pattern bits applied, then rst pulsed low for one edge in place of the final 1, then 1 -> outp=0. The next full 1011 is detected normally.
- With MEALY_DET_COUNT_EN, feed 300 overlapping detections (1 followed by 011 repeated) -> det_cnt saturates at 255. One reset edge -> det_cnt=0.
